picc_tx_encoder: RTL and testbench



---
 rtl/picc_tx_encoder.sv | 200 ++++++++++++++++++++
 tb/tb_picc_tx_encoder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/picc_tx_encoder.sv
// ISO/IEC 14443A Type A PICC->PCD bit encoder at 106 kbit/s.
// Turns a handshaked bit stream into Manchester-coded, subcarrier-modulated
// load-modulation drive: SOC (sequence D), one D/E per data bit, then EOC (F).
// Every output except in_ready is a flop. The next-cycle counter and state
// values are computed combinationally, so lm_out reaches its new level on the
// same clock edge that moves the counters.
module picc_tx_encoder #(
  parameter int BIT_LEN  = 128,
  parameter int SUB_HALF = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic in_data,
  input  logic in_last,
  input  logic in_valid,
  output logic in_ready,
  output logic lm_out,
  output logic idle,
  output logic done,
  output logic underrun
);

  localparam int BW = $clog2(BIT_LEN);
  localparam int SW = $clog2(2 * SUB_HALF);

  localparam logic [BW-1:0] LP_BIT_MAX  = BW'(BIT_LEN - 1);
  localparam logic [BW-1:0] LP_BIT_HALF = BW'(BIT_LEN / 2);
  localparam logic [SW-1:0] LP_SUB_MAX  = SW'(2 * SUB_HALF - 1);
  localparam logic [SW-1:0] LP_SUB_HALF = SW'(SUB_HALF);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SOC  = 2'd1,
    S_DATA = 2'd2,
    S_EOC  = 2'd3
  } state_t;

  state_t        r_state;
  logic [BW-1:0] r_bit_cnt;
  logic [SW-1:0] r_sub_cnt;
  logic          r_bit_val;   // value of the data bit currently on air
  logic          r_last;      // current data bit closes the frame
  logic          r_uflag;     // frame ended through an underrun
  logic          r_lm;
  logic          r_idle;
  logic          r_done;
  logic          r_underrun;

  state_t        w_state_n;
  logic [BW-1:0] w_bit_n;
  logic [SW-1:0] w_sub_n;
  logic          w_bit_val_n;
  logic          w_last_n;
  logic          w_uflag_n;
  logic          w_done_n;
  logic          w_underrun_n;
  logic          w_lm_n;
  logic          w_sample;
  logic          w_in_ready;
  logic          w_sub_on_n;

  // Sample point and the source handshake (no request after the final bit).
  always_comb begin
    w_sample   = 1'b0;
    w_in_ready = 1'b0;
    if ((r_state == S_SOC || r_state == S_DATA) && (r_bit_cnt == LP_BIT_MAX)) begin
      w_sample   = 1'b1;
      w_in_ready = !((r_state == S_DATA) && r_last);
    end else begin
      w_sample   = 1'b0;
      w_in_ready = 1'b0;
    end
  end

  // Next-state, counter and pulse decisions for the frame sequencer.
  always_comb begin
    w_state_n    = r_state;
    w_bit_n      = {BW{1'b0}};
    w_sub_n      = {SW{1'b0}};
    w_bit_val_n  = r_bit_val;
    w_last_n     = r_last;
    w_uflag_n    = r_uflag;
    w_done_n     = 1'b0;
    w_underrun_n = 1'b0;

    if (r_state != S_IDLE) begin
      if (r_bit_cnt == LP_BIT_MAX) begin
        w_bit_n = {BW{1'b0}};
        w_sub_n = {SW{1'b0}};
      end else begin
        w_bit_n = r_bit_cnt + {{(BW-1){1'b0}}, 1'b1};
        if (r_sub_cnt == LP_SUB_MAX) begin
          w_sub_n = {SW{1'b0}};
        end else begin
          w_sub_n = r_sub_cnt + {{(SW-1){1'b0}}, 1'b1};
        end
      end
    end else begin
      w_bit_n = {BW{1'b0}};
      w_sub_n = {SW{1'b0}};
    end

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_n = S_SOC;
          w_last_n  = 1'b0;
          w_uflag_n = 1'b0;
        end else begin
          w_state_n = S_IDLE;
        end
      end
      S_SOC, S_DATA: begin
        if (w_sample) begin
          if ((r_state == S_DATA) && r_last) begin
            w_state_n = S_EOC;
          end else if (in_valid) begin
            w_state_n   = S_DATA;
            w_bit_val_n = in_data;
            w_last_n    = in_last;
          end else begin
            w_state_n    = S_EOC;
            w_uflag_n    = 1'b1;
            w_underrun_n = 1'b1;
          end
        end else begin
          w_state_n = r_state;
        end
      end
      S_EOC: begin
        if (r_bit_cnt == LP_BIT_MAX) begin
          w_state_n = S_IDLE;
          w_done_n  = !r_uflag;
        end else begin
          w_state_n = S_EOC;
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  // Modulation level for the next cycle: D = subcarrier in first half-bit,
  // E = subcarrier in second half-bit, F = no modulation.
  always_comb begin
    w_lm_n     = 1'b0;
    w_sub_on_n = (w_sub_n < LP_SUB_HALF);
    case (w_state_n)
      S_SOC: begin
        w_lm_n = (w_bit_n < LP_BIT_HALF) && w_sub_on_n;
      end
      S_DATA: begin
        if (w_bit_val_n) begin
          w_lm_n = (w_bit_n < LP_BIT_HALF) && w_sub_on_n;
        end else begin
          w_lm_n = (w_bit_n >= LP_BIT_HALF) && w_sub_on_n;
        end
      end
      default: begin
        w_lm_n = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= {BW{1'b0}};
      r_sub_cnt  <= {SW{1'b0}};
      r_bit_val  <= 1'b0;
      r_last     <= 1'b0;
      r_uflag    <= 1'b0;
      r_lm       <= 1'b0;
      r_idle     <= 1'b1;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_bit_cnt  <= w_bit_n;
      r_sub_cnt  <= w_sub_n;
      r_bit_val  <= w_bit_val_n;
      r_last     <= w_last_n;
      r_uflag    <= w_uflag_n;
      r_lm       <= w_lm_n;
      r_idle     <= (w_state_n == S_IDLE);
      r_done     <= w_done_n;
      r_underrun <= w_underrun_n;
    end
  end

  assign in_ready = w_in_ready;
  assign lm_out   = r_lm;
  assign idle     = r_idle;
  assign done     = r_done;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_picc_tx_encoder.sv
// Self-checking bench for picc_tx_encoder: a default-parameter instance and a
// BIT_LEN=64/SUB_HALF=4 instance share the stimulus inputs. Expected waveforms
// come from a cycle-indexed model of the frame (SOC, data sequences, EOC).
module tb_picc_tx_encoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic in_data = 1'b0;
  logic in_last = 1'b0;
  logic in_valid = 1'b0;

  logic rdy0, lm0, idle0, done0, und0;
  logic rdy1, lm1, idle1, done1, und1;

  int checks = 0;
  int failures = 0;

  logic cur_sel = 1'b0;
  logic tx_bits [0:15];
  int   n_bits = 0;
  int   drop_idx = -1;
  int   glitch_c = -1;
  logic has_last = 1'b1;

  logic c_lm, c_rdy, c_idle, c_done, c_und;
  assign c_lm   = cur_sel ? lm1   : lm0;
  assign c_rdy  = cur_sel ? rdy1  : rdy0;
  assign c_idle = cur_sel ? idle1 : idle0;
  assign c_done = cur_sel ? done1 : done0;
  assign c_und  = cur_sel ? und1  : und0;

  picc_tx_encoder u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
    .in_last(in_last), .in_valid(in_valid), .in_ready(rdy0), .lm_out(lm0),
    .idle(idle0), .done(done0), .underrun(und0)
  );

  picc_tx_encoder #(.BIT_LEN(64), .SUB_HALF(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
    .in_last(in_last), .in_valid(in_valid), .in_ready(rdy1), .lm_out(lm1),
    .idle(idle1), .done(done1), .underrun(und1)
  );

  always #5 clk = ~clk;

  // Expected lm_out in cycle c (c=1 is the first cycle after start).
  function automatic logic model_lm(int c, int bl, int sh, int k, int t);
    int s, off;
    logic is_d, sub;
    if (c < 1 || c > t) return 1'b0;
    s   = (c - 1) / bl;
    off = (c - 1) % bl;
    if (s == 0) is_d = 1'b1;
    else if (s <= k) is_d = tx_bits[s-1];
    else return 1'b0;
    sub = ((off % (2 * sh)) < sh);
    return is_d ? ((off < bl / 2) && sub) : ((off >= bl / 2) && sub);
  endfunction

  // Present the bit the encoder will sample at the next sample point.
  task automatic set_inputs(input int c, input int bl);
    int j;
    j = (c == 0) ? 0 : (c - 1) / bl;
    in_data  = (j < n_bits) ? tx_bits[j] : 1'b0;
    in_valid = (drop_idx < 0) || (j < drop_idx);
    in_last  = has_last && (j >= n_bits - 1);
  endtask

  task automatic wait_both_idle();
    int i;
    for (i = 0; i < 3000; i++) begin
      if (idle0 && idle1) break;
      @(posedge clk); #1;
    end
    checks++;
    if (!(idle0 && idle1)) begin
      failures++;
      $display("FAIL wait_idle: idle0=%0b idle1=%0b required both 1", idle0, idle1);
    end
  endtask

  task automatic run_frame(input logic sel, input string name);
    int bl, sh, k, t, nsamp;
    logic e_lm, e_idle, e_done, e_und, e_rdy;
    bl = sel ? 64 : 128;
    sh = sel ? 4 : 8;
    k = (drop_idx >= 0) ? drop_idx : n_bits;
    t = (k + 2) * bl;
    nsamp = (drop_idx >= 0) ? drop_idx + 1 : n_bits;
    wait_both_idle();
    cur_sel = sel;
    #0;
    start = 1'b1;
    set_inputs(0, bl);
    for (int c = 1; c <= t + 2; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      e_lm   = model_lm(c, bl, sh, k, t);
      e_idle = (c > t);
      e_done = (drop_idx < 0) && (c == t + 1);
      e_und  = (drop_idx >= 0) && (c == nsamp * bl + 1);
      e_rdy  = ((c % bl) == 0) && (c / bl >= 1) && (c / bl <= nsamp);
      checks += 5;
      if (c_lm !== e_lm) begin
        failures++;
        if (failures < 40) $display("FAIL %s lm_out cycle %0d: got %0b want %0b", name, c, c_lm, e_lm);
      end
      if (c_idle !== e_idle) begin
        failures++;
        if (failures < 40) $display("FAIL %s idle cycle %0d: got %0b want %0b", name, c, c_idle, e_idle);
      end
      if (c_done !== e_done) begin
        failures++;
        if (failures < 40) $display("FAIL %s done cycle %0d: got %0b want %0b", name, c, c_done, e_done);
      end
      if (c_und !== e_und) begin
        failures++;
        if (failures < 40) $display("FAIL %s underrun cycle %0d: got %0b want %0b", name, c, c_und, e_und);
      end
      if (c_rdy !== e_rdy) begin
        failures++;
        if (failures < 40) $display("FAIL %s in_ready cycle %0d: got %0b want %0b", name, c, c_rdy, e_rdy);
      end
      set_inputs(c, bl);
      if (c == glitch_c) start = 1'b1;
    end
    glitch_c = -1;
  endtask

  task automatic load_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) tx_bits[i] = b[i];
    n_bits = 8;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 10;
    if (lm0 !== 1'b0 || lm1 !== 1'b0) begin failures++; $display("FAIL reset lm_out: got %0b/%0b want 0", lm0, lm1); end
    if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin failures++; $display("FAIL reset in_ready: got %0b/%0b want 0", rdy0, rdy1); end
    if (done0 !== 1'b0 || done1 !== 1'b0) begin failures++; $display("FAIL reset done: got %0b/%0b want 0", done0, done1); end
    if (und0 !== 1'b0 || und1 !== 1'b0) begin failures++; $display("FAIL reset underrun: got %0b/%0b want 0", und0, und1); end
    if (idle0 !== 1'b1 || idle1 !== 1'b1) begin failures++; $display("FAIL reset idle: got %0b/%0b want 1", idle0, idle1); end
    checks -= 5;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_bit(input logic sel);
    tx_bits[0] = 1'b1; n_bits = 1; has_last = 1'b1; drop_idx = -1;
    run_frame(sel, sel ? "single_bit_short" : "single_bit");
  endtask

  task automatic test_byte_a5();
    load_byte(8'hA5); has_last = 1'b1; drop_idx = -1;
    run_frame(1'b0, "byte_a5");
  endtask

  task automatic test_underrun_mid();
    load_byte(8'h3C); has_last = 1'b0; drop_idx = 3;
    run_frame(1'b0, "underrun_mid");
  endtask

  task automatic test_empty_frame();
    n_bits = 0; has_last = 1'b0; drop_idx = 0;
    run_frame(1'b0, "empty_frame");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      n_bits = $urandom_range(1, 6);
      for (int i = 0; i < 16; i++) tx_bits[i] = 1'($urandom_range(0, 1));
      has_last = 1'b1; drop_idx = -1;
      run_frame(1'b0, "random");
    end
  endtask

  task automatic test_start_ignored();
    load_byte(8'hA5); has_last = 1'b1; drop_idx = -1;
    glitch_c = 3 * 128 + 5;
    run_frame(1'b0, "start_ignored");
  endtask

  task automatic test_reset_mid_frame();
    logic saw;
    wait_both_idle();
    cur_sel = 1'b0;
    tx_bits[0] = 1'b1; n_bits = 1; has_last = 1'b1; drop_idx = -1;
    start = 1'b1;
    set_inputs(0, 128);
    for (int c = 1; c <= 128 + 33; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      set_inputs(c, 128);
    end
    checks++;
    if (lm0 !== 1'b1) begin failures++; $display("FAIL reset_mid pre lm_out: got %0b want 1", lm0); end
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (lm0 !== 1'b0) begin failures++; $display("FAIL reset_mid lm_out: got %0b want 0", lm0); end
    if (idle0 !== 1'b1) begin failures++; $display("FAIL reset_mid idle: got %0b want 1", idle0); end
    if (rdy0 !== 1'b0) begin failures++; $display("FAIL reset_mid in_ready: got %0b want 0", rdy0); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1;
      saw = saw | done0 | und0 | lm0 | !idle0;
    end
    checks++;
    if (saw !== 1'b0) begin failures++; $display("FAIL reset_mid quiet: got activity=%0b want 0", saw); end
    run_frame(1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_single_bit(1'b0);
    test_byte_a5();
    test_underrun_mid();
    test_empty_frame();
    test_random();
    test_start_ignored();
    test_reset_mid_frame();
    test_single_bit(1'b1);
    wait_both_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
